// File: rtl/seq_det_pkg.sv
// Shared types, widths and helpers for the serial sequence detector.
package seq_det_pkg;

    localparam int HIST_W = 8;   // history register width = longest pattern
    localparam int CNT_W  = 8;   // match counter width
    localparam int BITS_W = 16;  // bit budget / bit counter width
    localparam int FILL_W = 4;   // fill count holds 0..8
    localparam int LEN_W  = 4;   // cfg_len width

    // status meaning, valid while done = 1
    localparam logic STATUS_TARGET = 1'b0;  // target number of matches reached
    localparam logic STATUS_BUDGET = 1'b1;  // bit budget ran out first

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic [HIST_W-1:0] pattern;
        logic [LEN_W-1:0]  len;
        logic              overlap;
        logic [CNT_W-1:0]  target;
        logic [BITS_W-1:0] max_bits;
    } cfg_t;

    // Mask selecting the low 'len' bits of the history / pattern.
    function automatic logic [HIST_W-1:0] len_mask(input logic [LEN_W-1:0] len);
        logic [HIST_W-1:0] m;
        for (int i = 0; i < HIST_W; i++) begin
            m[i] = (LEN_W'(i) < len);
        end
        return m;
    endfunction

    // Only lengths 1..8 fit the history register.
    function automatic logic len_legal(input logic [LEN_W-1:0] len);
        return (len >= LEN_W'(1)) && (len <= LEN_W'(HIST_W));
    endfunction

endpackage

// File: rtl/seq_match_core.sv
// History shift register, saturating fill count and pattern comparator.
// 'hit' is combinational and already includes the bit being shifted in.
module seq_match_core
    import seq_det_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              shift,
    input  logic              clear,
    input  logic              bit_in,
    input  logic [HIST_W-1:0] pattern,
    input  logic [LEN_W-1:0]  len,
    input  logic              overlap,
    output logic              hit
);

    logic [HIST_W-1:0] hist;
    logic [HIST_W-1:0] hist_n;
    logic [FILL_W-1:0] fill;
    logic [FILL_W-1:0] fill_n;
    logic [HIST_W-1:0] mask;

    // Look-ahead values with the incoming bit, used for the compare.
    always_comb begin
        hist_n = {hist[HIST_W-2:0], bit_in};
        fill_n = (fill == FILL_W'(HIST_W)) ? fill : fill + FILL_W'(1);
        mask   = len_mask(len);
        hit    = shift && (fill_n >= len) && (((hist_n ^ pattern) & mask) == '0);
    end

    // Shift on every accepted bit; without overlap a match restarts the fill.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            hist <= '0;
            fill <= '0;
        end else if (shift) begin
            hist <= hist_n;
            fill <= (hit && !overlap) ? '0 : fill_n;
        end
    end

endmodule

// File: rtl/seq_det_ctrl.sv
// Serial sequence detector controller: config handshake, run control,
// match counting and termination on target or bit budget.
// Handshake: a config is taken on any cycle with cfg_valid && cfg_ready;
// cfg_ready is high in every state except RUN and does not depend on cfg_valid.
module seq_det_ctrl
    import seq_det_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [HIST_W-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]  cfg_len,
    input  logic              cfg_overlap,
    input  logic [CNT_W-1:0]  cfg_target,
    input  logic [BITS_W-1:0] cfg_max_bits,
    input  logic              start,
    input  logic              abort,
    input  logic              in_valid,
    input  logic              in,
    output logic              busy,
    output logic              match,
    output logic [CNT_W-1:0]  match_cnt,
    output logic              done,
    output logic              status,
    output logic              cfg_err
);

    state_t            state, state_n;
    cfg_t              cfg, cfg_n;
    logic              match_n;
    logic [CNT_W-1:0]  cnt_n;
    logic              done_n;
    logic              status_n;
    logic              err_n;
    logic [BITS_W-1:0] bit_cnt, bit_cnt_n;

    logic              shift;
    logic              clear;
    logic              hit;
    logic [CNT_W-1:0]  target_eff;
    logic [CNT_W-1:0]  cnt_inc;
    logic [BITS_W-1:0] bits_inc;
    logic              target_hit;
    logic              budget_hit;

    assign cfg_ready = (state != RUN);
    assign busy      = (state == RUN);
    assign shift     = (state == RUN) && in_valid;
    // a same-cycle cfg_valid takes priority over start
    assign clear     = ((state == ARMED) || (state == DONE)) && start && !cfg_valid;

    seq_match_core u_core (
        .clk     (clk),
        .rst     (rst),
        .shift   (shift),
        .clear   (clear),
        .bit_in  (in),
        .pattern (cfg.pattern),
        .len     (cfg.len),
        .overlap (cfg.overlap),
        .hit     (hit)
    );

    // Next-state and next-output logic for the run FSM.
    always_comb begin
        state_n    = state;
        cfg_n      = cfg;
        match_n    = 1'b0;
        cnt_n      = match_cnt;
        done_n     = done;
        status_n   = status;
        err_n      = 1'b0;
        bit_cnt_n  = bit_cnt;
        target_eff = (cfg.target == '0) ? CNT_W'(1) : cfg.target;
        cnt_inc    = (match_cnt == '1) ? match_cnt : match_cnt + CNT_W'(1);
        bits_inc   = bit_cnt + BITS_W'(1);
        target_hit = hit && (cnt_inc >= target_eff);
        budget_hit = shift && (cfg.max_bits != '0) && (bits_inc == cfg.max_bits);

        case (state)
            RUN: begin
                if (shift) begin
                    bit_cnt_n = bits_inc;
                    if (hit) begin
                        match_n = 1'b1;
                        cnt_n   = cnt_inc;
                    end
                end
                if (abort) begin
                    state_n = ARMED;
                    done_n  = 1'b0;
                end else if (target_hit) begin
                    state_n  = DONE;
                    done_n   = 1'b1;
                    status_n = STATUS_TARGET;
                end else if (budget_hit) begin
                    state_n  = DONE;
                    done_n   = 1'b1;
                    status_n = STATUS_BUDGET;
                end
            end
            default: begin
                if (cfg_valid) begin
                    if (len_legal(cfg_len)) begin
                        cfg_n.pattern  = cfg_pattern;
                        cfg_n.len      = cfg_len;
                        cfg_n.overlap  = cfg_overlap;
                        cfg_n.target   = cfg_target;
                        cfg_n.max_bits = cfg_max_bits;
                        done_n         = 1'b0;
                        state_n        = ARMED;
                    end else begin
                        err_n   = 1'b1;
                        state_n = IDLE;
                    end
                end else if (clear) begin
                    state_n   = RUN;
                    cnt_n     = '0;
                    bit_cnt_n = '0;
                    done_n    = 1'b0;
                    status_n  = 1'b0;
                end
            end
        endcase
    end

    // State and output registers; reset discards any run in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cfg       <= '0;
            match     <= 1'b0;
            match_cnt <= '0;
            done      <= 1'b0;
            status    <= 1'b0;
            cfg_err   <= 1'b0;
            bit_cnt   <= '0;
        end else begin
            state     <= state_n;
            cfg       <= cfg_n;
            match     <= match_n;
            match_cnt <= cnt_n;
            done      <= done_n;
            status    <= status_n;
            cfg_err   <= err_n;
            bit_cnt   <= bit_cnt_n;
        end
    end

endmodule

// File: doc/seq_det_ctrl.md
SEQ_DET_CTRL -- requirements
Module: seq_det_ctrl

Interface
REQ-001 The block SHALL have these ports:
- clk  input  1  sole clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- cfg_valid  input  1  configuration offered.
- cfg_ready  output  1  configuration can be accepted.
- cfg_pattern  input  8  pattern, right-aligned; bit 0 = most recent bit.
- cfg_len  input  4  pattern length, legal 1..8.
- cfg_overlap  input  1  1 = overlapping matches, 0 = history cleared after a match.
- cfg_target  input  8  matches required for success, 0 treated as 1.
- cfg_max_bits  input  16  bit budget per run.
- start  input  1  begin a run with the stored config.
- abort  input  1  end the current run, no status.
- in_valid  input  1  serial bit present.
- in  input  1  serial data bit.
- busy  output  1  run in progress.
- match  output  1  one-cycle pulse per detected match.
- match_cnt  output  8  matches in the current or last run.
- done  output  1  run finished; held until next start, cfg accept or reset.
- status  output  1  valid with done: 0 = target reached, 1 = bit budget exhausted.
- cfg_err  output  1  one-cycle pulse on a rejected configuration.

Function
REQ-002 The FSM SHALL have four states: IDLE, ARMED, RUN and DONE.
REQ-003 cfg_ready SHALL be 1 in IDLE, ARMED and DONE, and 0 in RUN.
REQ-004 A cfg_valid and cfg_ready cycle with cfg_len in 1..8 SHALL latch all cfg_* inputs, clear done, and go to ARMED.
REQ-005 A cfg_valid and cfg_ready cycle with cfg_len of 0 or 9..15 SHALL pulse cfg_err on the next cycle, keep the old config, and go to IDLE.
REQ-006 start SHALL be ignored in IDLE and in RUN.
REQ-007 start in ARMED or DONE SHALL go to RUN and clear the history, fill count, match_cnt, bit counter, done and status.
REQ-008 If start and cfg_valid occur in the same cycle, cfg_valid SHALL win and start SHALL be ignored.
REQ-009 In RUN, each in_valid cycle SHALL shift `in` into the 8-bit history at bit 0, increment the saturating fill count (max 8) and increment the bit counter; cycles without in_valid SHALL change nothing.
REQ-010 A match SHALL be detected when fill count >= len and history[len-1:0] == pattern[len-1:0], both evaluated including the current bit.
REQ-011 match SHALL pulse exactly one cycle after the in_valid cycle that completed the pattern, and match_cnt SHALL increment in that same cycle.
REQ-012 When cfg_overlap = 0, a match SHALL reset the fill count to 0, so the next match needs len fresh bits.
REQ-013 When match_cnt reaches the target, the FSM SHALL go to DONE with done = 1 and status = 0, and busy SHALL drop in that cycle.
REQ-014 When the bit counter reaches cfg_max_bits without reaching the target, the FSM SHALL go to DONE with status = 1.
REQ-015 If the target and the bit budget are both reached on the same bit, status SHALL be 0.
REQ-016 cfg_max_bits = 0 SHALL mean an unlimited bit budget.
REQ-017 abort in RUN SHALL go to ARMED with done = 0 and match_cnt held; abort SHALL have no effect in any other state.
REQ-018 If abort and a final match occur in the same cycle, abort SHALL win, but the match pulse and the count increment SHALL still occur.
REQ-019 match_cnt SHALL saturate at 255.
REQ-020 busy SHALL equal (state == RUN).

Reset
REQ-021 When rst = 1 at a clock edge, the block SHALL enter IDLE and set to 0: match, match_cnt, done, status, cfg_err, busy, history, fill count, bit counter and stored config; cfg_ready SHALL be 1 the cycle after.
REQ-022 Reset asserted mid-RUN SHALL discard the run, with no done and no match pulse.

Structure
REQ-023 The state enum, history width (8), counter widths (8, 16) and the status encoding SHALL live in the shared package seq_det_pkg.
REQ-024 The history shift register, fill count and compare logic SHALL be one sub-module, seq_match_core, controlled by seq_det_ctrl through shift, clear and hit signals.

Verification
REQ-025 Pattern 1101, len 4, overlap 1, target 2; stream 1,1,0,1,1,0,1 -> match pulses after bits 4 and 7, match_cnt = 2, done with status 0.
REQ-026 Same stream with overlap 0, target 2, max_bits 7 -> one match after bit 4, then done with status 1 after bit 7, match_cnt = 1.
REQ-027 cfg_len = 0, then start -> cfg_err pulses, FSM stays IDLE, start ignored, busy stays 0.
REQ-028 Pattern 11, len 2, target 1, max_bits 2; stream 1,1 -> done with status 0, because success wins the simultaneous case.
REQ-029 rst asserted after 3 bits of a run -> all outputs 0 the next cycle; a new cfg and start then gives a correct fresh run.
REQ-030 in_valid gaps inserted between the bits of REQ-025 -> identical match_cnt and status; each match pulse follows its completing bit by exactly 1 cycle.
